ddr_verify_frame_checker: RTL
=============================

Name: ddr_verify_frame_checker

Overview:
- Sits directly upstream of the on-chip debug capture core in the DDR frame-buffer verify design.
- Consumes the frame-buffer read stream and checks each word against an incrementing reference pattern.
- Checks per-frame word count and accumulates error statistics.
- Packs a 35-bit probe vector (O_TRIG) that drives the capture core's 35-bit trigger input directly.

Parameters:
- DATA_WIDTH, 32: read data width; fixed at 32 because O_TRIG is 35 bits.
- FRAME_WORDS, 1024: expected valid words per frame (1..65535).
- PATTERN_SEED, 32'h0000_0000: expected value of the first word of every frame.
- ERR_CNT_WIDTH, 16: width of the saturating error counter.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- I_FRAME_START  in  1  single-cycle pulse marking the start of a read frame.
- I_DATA_VALID  in  1  qualifies I_DATA.
- I_DATA  in  32  frame-buffer read data.
- I_FRAME_END  in  1  single-cycle pulse after or with the last word.
- I_CLR_STAT  in  1  synchronous pulse; clears O_ERR_CNT and O_FRAME_CNT.
- O_TRIG  out  35  probe bus to the capture core.
- O_ERR_CNT  out  16  saturating count of mismatched words.
- O_FRAME_CNT  out  16  completed frames; wraps at 65535 -> 0.
- O_LEN_ERR  out  1  sticky flag; frame length differed from FRAME_WORDS.
- O_FRAME_DONE  out  1  one-cycle pulse in the REPORT state.

Behaviour:
- Reset (RESET_N=0, asynchronous): all outputs 0; state IDLE; expected register = PATTERN_SEED; word counter = 0.
- States:
  - IDLE: wait for I_FRAME_START. Words arriving in IDLE are ignored.
  - CHECK: compare valid words. I_FRAME_END -> REPORT.
  - REPORT: one cycle; pulse O_FRAME_DONE; then IDLE.
- Start cycle: on I_FRAME_START, expected <= PATTERN_SEED, word counter <= 0, state <= CHECK. If I_DATA_VALID is also high, that word is compared against PATTERN_SEED and counts as word 0.
- I_FRAME_START in CHECK or REPORT: silently restart the frame. The old frame is not counted and no length check is made.
- Compare, per valid word in CHECK:
  - mismatch = (I_DATA != expected).
  - expected increments mod 2^32 (0xFFFF_FFFF wraps to 0).
  - word counter increments and saturates at 0xFFFF.
- Error counting: registered 1-cycle latency from the valid word to the O_ERR_CNT increment. O_ERR_CNT holds at 0xFFFF.
- Valid word together with I_FRAME_END: the word is checked and counted first. The length check uses the count including that word.
- Length check on entering REPORT: if final count != FRAME_WORDS, set O_LEN_ERR. It stays set until reset or I_CLR_STAT.
- O_FRAME_CNT increments in the REPORT cycle.
- I_CLR_STAT clears O_ERR_CNT, O_FRAME_CNT and O_LEN_ERR.
  - A same-cycle increment is lost; clear wins.
  - It does not affect state or the expected register.
- O_TRIG is fully registered and aligned 1 cycle after the input word:
  - [31:0] = I_DATA registered.
  - [32] = I_DATA_VALID registered, qualified by CHECK or by a start-cycle valid word.
  - [33] = mismatch pulse for that word.
  - [34] = frame active (state CHECK).
  - O_TRIG = 0 in reset.
- Reset asserted mid-frame: immediate return to IDLE with all outputs cleared. No partial frame is reported.

Decomposition:
- Shared package ddr_verify_pkg:
  - state encodings ST_IDLE, ST_CHECK, ST_REPORT.
  - TRIG bit indices TRIG_VALID_BIT=32, TRIG_ERR_BIT=33, TRIG_ACT_BIT=34.
  - DATA_WIDTH=32.
- One natural sub-module: ddr_verify_sat_cnt, a parameterised saturating counter with synchronous clear. It is reused for the error counter and the word counter.

Test Plan:
- Clean frame: start pulse, then 1024 valid words 0..1023 with no gaps, then end → O_ERR_CNT=0, O_LEN_ERR=0, O_FRAME_CNT=1, one O_FRAME_DONE pulse, O_TRIG[33] never high.
- Corrupted words: as the clean frame, but word 5 = 0xDEAD_BEEF and word 700 = 0 → O_ERR_CNT=2; O_TRIG[33] high exactly 1 cycle after each bad word, with O_TRIG[31:0] showing the bad data.
- Length and stats clear: frame with 1023 words → O_LEN_ERR=1, O_ERR_CNT=0; then I_CLR_STAT → O_LEN_ERR=0, O_FRAME_CNT=0.
- Pattern wrap: PATTERN_SEED=0xFFFF_FFFE, FRAME_WORDS=4, data FFFFFFFE, FFFFFFFF, 0, 1 → O_ERR_CNT=0.
- Restart and simultaneous events:
  - Second I_FRAME_START after 10 words, then 1024 good words → O_FRAME_CNT=1, O_LEN_ERR=0.
  - Start coincident with valid word = seed → no error.
  - Last word coincident with I_FRAME_END → count = 1024.
- Reset mid-frame, then saturation:
  - RESET_N low for 3 cycles at word 500 → all outputs 0, state IDLE; a following good frame passes.
  - 70000 mismatching words in one frame (FRAME_WORDS=65535) → O_ERR_CNT = 0xFFFF.

Source files
------------

// File: rtl/ddr_verify_pkg.sv
// ddr_verify_pkg: shared state encodings and probe-bus bit positions for the
// DDR frame-buffer verify slice.
`default_nettype none

package ddr_verify_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int TRIG_VALID_BIT = 32;
  localparam int TRIG_ERR_BIT   = 33;
  localparam int TRIG_ACT_BIT   = 34;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ddr_verify_sat_cnt.sv
// ddr_verify_sat_cnt: saturating up-counter with synchronous clear.
// With LOAD_ON_CLR set, an increment coincident with clear loads 1 instead of 0.
`default_nettype none

module ddr_verify_sat_cnt #(
  parameter int WIDTH       = 16,
  parameter bit LOAD_ON_CLR = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_max;

  assign w_max = &r_cnt;
  assign o_cnt = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= (LOAD_ON_CLR && i_inc) ? WIDTH'(1) : '0;
    end else if (i_inc && !w_max) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ddr_verify_frame_checker.sv
// ddr_verify_frame_checker: checks the frame-buffer read stream against an
// incrementing pattern, tracks frame length / error statistics, drives the probe bus.
`default_nettype none

module ddr_verify_frame_checker #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          FRAME_WORDS   = 1024,
  parameter logic [31:0] PATTERN_SEED  = 32'h0000_0000,
  parameter int          ERR_CNT_WIDTH = 16
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     I_FRAME_START,
  input  logic                     I_DATA_VALID,
  input  logic [DATA_WIDTH-1:0]    I_DATA,
  input  logic                     I_FRAME_END,
  input  logic                     I_CLR_STAT,
  output logic [34:0]              O_TRIG,
  output logic [ERR_CNT_WIDTH-1:0] O_ERR_CNT,
  output logic [15:0]              O_FRAME_CNT,
  output logic                     O_LEN_ERR,
  output logic                     O_FRAME_DONE
);

  import ddr_verify_pkg::*;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_expected;
  logic [DATA_WIDTH-1:0] w_exp_cur;
  logic                  w_cmp_en;
  logic                  w_mismatch;
  logic                  w_end_frame;
  logic [15:0]           w_word_cnt;
  logic [15:0]           w_final_cnt;
  logic [15:0]           r_frame_cnt;
  logic                  r_len_err;
  logic [34:0]           r_trig;

  // A start pulse restarts the frame from any state, so its word compares against the seed.
  assign w_cmp_en    = I_DATA_VALID && (I_FRAME_START || (r_state == ST_CHECK));
  assign w_exp_cur   = I_FRAME_START ? PATTERN_SEED : r_expected;
  assign w_mismatch  = w_cmp_en && (I_DATA != w_exp_cur);
  assign w_end_frame = (r_state == ST_CHECK) && I_FRAME_END && !I_FRAME_START;
  assign w_final_cnt = (w_cmp_en && !(&w_word_cnt)) ? w_word_cnt + 16'd1 : w_word_cnt;

  always_comb begin
    w_next = r_state;
    if (I_FRAME_START) begin
      w_next = ST_CHECK;
    end else begin
      case (r_state)
        ST_IDLE:   w_next = ST_IDLE;
        ST_CHECK:  if (I_FRAME_END) w_next = ST_REPORT;
        ST_REPORT: w_next = ST_IDLE;
        default:   w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_expected <= PATTERN_SEED;
    end else if (w_cmp_en) begin
      r_expected <= w_exp_cur + DATA_WIDTH'(1);
    end else if (I_FRAME_START) begin
      r_expected <= PATTERN_SEED;
    end
  end

  ddr_verify_sat_cnt #(
    .WIDTH       (16),
    .LOAD_ON_CLR (1'b1)
  ) u_word_cnt (
    .clk   (CLK),
    .rst_n (RESET_N),
    .i_clr (I_FRAME_START),
    .i_inc (w_cmp_en),
    .o_cnt (w_word_cnt)
  );

  ddr_verify_sat_cnt #(
    .WIDTH       (ERR_CNT_WIDTH),
    .LOAD_ON_CLR (1'b0)
  ) u_err_cnt (
    .clk   (CLK),
    .rst_n (RESET_N),
    .i_clr (I_CLR_STAT),
    .i_inc (w_mismatch),
    .o_cnt (O_ERR_CNT)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_frame_cnt <= '0;
      r_len_err   <= 1'b0;
    end else if (I_CLR_STAT) begin
      r_frame_cnt <= '0;
      r_len_err   <= 1'b0;
    end else begin
      if ((r_state == ST_REPORT) && !I_FRAME_START) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
      if (w_end_frame && (w_final_cnt != 16'(FRAME_WORDS))) begin
        r_len_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_trig <= '0;
    end else begin
      r_trig[TRIG_VALID_BIT-1:0] <= I_DATA;
      r_trig[TRIG_VALID_BIT]     <= w_cmp_en;
      r_trig[TRIG_ERR_BIT]       <= w_mismatch;
      r_trig[TRIG_ACT_BIT]       <= (r_state == ST_CHECK);
    end
  end

  assign O_TRIG       = r_trig;
  assign O_FRAME_CNT  = r_frame_cnt;
  assign O_LEN_ERR    = r_len_err;
  assign O_FRAME_DONE = (r_state == ST_REPORT);

endmodule

`default_nettype wire
